// File: rtl/game_fsm.sv
// game_fsm: match controller sequencing idle, countdown, fight and result with health and seconds tracking
module game_fsm #(
  parameter int TICK_DIV      = 50000000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int FIGHT_SEC     = 99,
  parameter int MAX_HEALTH    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [2:0] game_state,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [6:0] sec_left,
  output logic       sec_tick
);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, FIGHT, P1_WIN, P2_WIN, EQ} state_t;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0] HMAX = 3'(MAX_HEALTH);
  localparam logic [6:0] CD_SEC = 7'(COUNTDOWN_SEC);
  localparam logic [6:0] FT_SEC = 7'(FIGHT_SEC);
  state_t st_q, st_d;
  logic [2:0] p1_q, p1_d, p2_q, p2_d;
  logic [6:0] sec_q, sec_d;
  logic [PW-1:0] psc_q, psc_d;
  logic start_q, tick_q, tick, start_edge;
  always_comb begin
    start_edge = start & ~start_q;
    tick = psc_q == PSC_MAX;
    st_d = st_q;
    p1_d = p1_q;
    p2_d = p2_q;
    sec_d = sec_q;
    case (st_q)
      IDLE: begin
        p1_d = HMAX;
        p2_d = HMAX;
        st_d = start_edge ? COUNTDOWN : IDLE;
        sec_d = start_edge ? CD_SEC : 7'd0;
      end
      COUNTDOWN: begin
        if (tick && sec_q == 7'd1) begin
          st_d = FIGHT;
          sec_d = FT_SEC;
          p1_d = HMAX;
          p2_d = HMAX;
        end else if (tick) sec_d = sec_q - 7'd1;
      end
      FIGHT: begin
        p2_d = (p1_hit && p2_q != 3'd0) ? p2_q - 3'd1 : p2_q;
        p1_d = (p2_hit && p1_q != 3'd0) ? p1_q - 3'd1 : p1_q;
        if (p1_d == 3'd0 || p2_d == 3'd0) begin
          st_d = (p1_d == p2_d) ? EQ : (p2_d == 3'd0) ? P1_WIN : P2_WIN;
          sec_d = 7'd0;
        end else if (tick && sec_q == 7'd1) begin
          st_d = (p1_d > p2_d) ? P1_WIN : (p1_d < p2_d) ? P2_WIN : EQ;
          sec_d = 7'd0;
        end else if (tick) sec_d = sec_q - 7'd1;
      end
      P1_WIN, P2_WIN, EQ: begin
        sec_d = 7'd0;
        if (start_edge) begin
          st_d = IDLE;
          p1_d = HMAX;
          p2_d = HMAX;
        end
      end
      default: begin
        st_d = IDLE;
        sec_d = 7'd0;
        p1_d = HMAX;
        p2_d = HMAX;
      end
    endcase
    psc_d = (st_d != st_q || tick) ? '0 : psc_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      p1_q <= HMAX;
      p2_q <= HMAX;
      sec_q <= 7'd0;
      psc_q <= '0;
      tick_q <= 1'b0;
      start_q <= 1'b1;
    end else begin
      st_q <= st_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      sec_q <= sec_d;
      psc_q <= psc_d;
      tick_q <= tick;
      start_q <= start;
    end
  end
  assign game_state = st_q;
  assign p1_health = p1_q;
  assign p2_health = p2_q;
  assign sec_left = sec_q;
  assign sec_tick = tick_q;
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed scoreboard bench for game_fsm with a cycle reference model
module tb_game_fsm;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1, p1_hit = 1'b0, p2_hit = 1'b0;
  logic [2:0] game_state, p1_health, p2_health;
  logic [6:0] sec_left;
  logic sec_tick;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [2:0] st;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [6:0] sec;
    logic tk;
  } exp_t;
  exp_t sb[$];
  logic [2:0] m_st = 3'd0, m_p1 = 3'd3, m_p2 = 3'd3;
  logic [6:0] m_sec = 7'd0;
  logic [1:0] m_psc = 2'd0;
  logic m_sq = 1'b1, m_tk = 1'b0;
  game_fsm #(.TICK_DIV(4), .COUNTDOWN_SEC(3), .FIGHT_SEC(5), .MAX_HEALTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .game_state(game_state), .p1_health(p1_health), .p2_health(p2_health),
    .sec_left(sec_left), .sec_tick(sec_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic r, input logic s, input logic h1, input logic h2);
    logic ed, tk;
    logic [2:0] n_st, n_p1, n_p2;
    logic [6:0] n_sec;
    if (r) begin
      m_st = 0; m_p1 = 3; m_p2 = 3; m_sec = 0; m_psc = 0; m_sq = 1; m_tk = 0;
      return;
    end
    ed = s && !m_sq;
    tk = m_psc == 2'd3;
    n_st = m_st; n_p1 = m_p1; n_p2 = m_p2; n_sec = m_sec;
    if (m_st == 0) begin
      if (ed) begin n_st = 1; n_sec = 3; end
    end else if (m_st == 1) begin
      if (tk) begin
        if (m_sec == 1) begin n_st = 2; n_sec = 5; n_p1 = 3; n_p2 = 3; end
        else n_sec = m_sec - 1;
      end
    end else if (m_st == 2) begin
      if (h1 && n_p2 > 0) n_p2 = n_p2 - 1;
      if (h2 && n_p1 > 0) n_p1 = n_p1 - 1;
      if (n_p1 == 0 && n_p2 == 0) begin n_st = 5; n_sec = 0; end
      else if (n_p2 == 0) begin n_st = 3; n_sec = 0; end
      else if (n_p1 == 0) begin n_st = 4; n_sec = 0; end
      else if (tk && m_sec == 1) begin
        n_sec = 0;
        if (n_p1 > n_p2) n_st = 3;
        else if (n_p2 > n_p1) n_st = 4;
        else n_st = 5;
      end else if (tk) n_sec = m_sec - 1;
    end else begin
      if (ed) begin n_st = 0; n_p1 = 3; n_p2 = 3; end
    end
    m_psc = (n_st != m_st || tk) ? 2'd0 : m_psc + 2'd1;
    m_st = n_st; m_p1 = n_p1; m_p2 = n_p2; m_sec = n_sec; m_tk = tk; m_sq = s;
  endtask
  task automatic step(input logic r, input logic s, input logic h1, input logic h2);
    exp_t e;
    rst = r; start = s; p1_hit = h1; p2_hit = h2;
    model(r, s, h1, h2);
    sb.push_back('{m_st, m_p1, m_p2, m_sec, m_tk});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_state", 8'(game_state), 8'(e.st));
    chk("sb_p1", 8'(p1_health), 8'(e.p1));
    chk("sb_p2", 8'(p2_health), 8'(e.p2));
    chk("sb_sec", 8'(sec_left), 8'(e.sec));
    chk("sb_tick", 8'(sec_tick), 8'(e.tk));
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  task automatic press();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask
  task automatic to_fight();
    press();
    idle_n(12);
    chk("enter_fight", 8'(game_state), 8'd2);
    chk("fight_sec", 8'(sec_left), 8'd5);
  endtask
  initial begin
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_state", 8'(game_state), 8'd0);
    chk("rst_health", 8'({p1_health, p2_health}), 8'({3'd3, 3'd3}));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("held_start", 8'(game_state), 8'd0);
    press();
    chk("cd_state", 8'(game_state), 8'd1);
    chk("cd_sec3", 8'(sec_left), 8'd3);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    chk("cd_sec2", 8'(sec_left), 8'd2);
    chk("cd_tick", 8'(sec_tick), 8'd1);
    chk("cd_hit_ignored", 8'({p1_health, p2_health}), 8'({3'd3, 3'd3}));
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    chk("cd_to_fight", 8'(game_state), 8'd2);
    chk("cd_fight_sec", 8'(sec_left), 8'd5);
    step(0, 0, 1, 0);
    chk("ko_p2_2", 8'(p2_health), 8'd2);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("ko_p2_1", 8'(p2_health), 8'd1);
    step(0, 0, 1, 0);
    chk("ko_p2_0", 8'(p2_health), 8'd0);
    chk("ko_p1win", 8'(game_state), 8'd3);
    step(0, 0, 1, 1);
    chk("ko_frozen_p1", 8'(p1_health), 8'd3);
    chk("ko_frozen_st", 8'(game_state), 8'd3);
    press();
    chk("result_to_idle", 8'(game_state), 8'd0);
    chk("result_health", 8'({p1_health, p2_health}), 8'({3'd3, 3'd3}));
    to_fight();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("dbl_11", 8'({p1_health, p2_health}), 8'({3'd1, 3'd1}));
    step(0, 0, 1, 1);
    chk("dbl_eq", 8'(game_state), 8'd5);
    chk("dbl_00", 8'({p1_health, p2_health}), 8'd0);
    press();
    to_fight();
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    idle_n(17);
    chk("to21_pre", 8'(sec_left), 8'd1);
    step(0, 0, 0, 0);
    chk("to21_state", 8'(game_state), 8'd3);
    chk("to21_sec", 8'(sec_left), 8'd0);
    press();
    to_fight();
    step(0, 0, 1, 1);
    idle_n(19);
    chk("to22_eq", 8'(game_state), 8'd5);
    press();
    to_fight();
    step(0, 0, 1, 1);
    idle_n(18);
    step(0, 0, 0, 1);
    chk("to_hit_state", 8'(game_state), 8'd4);
    chk("to_hit_health", 8'({p1_health, p2_health}), 8'({3'd1, 3'd2}));
    press();
    to_fight();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rstf_state", 8'(game_state), 8'd0);
    chk("rstf_health", 8'({p1_health, p2_health}), 8'({3'd3, 3'd3}));
    chk("rstf_sec", 8'(sec_left), 8'd0);
    idle_n(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
